memory_read_split: RTL and testbench

- Parametrised read splitter between the execute-side read port and the TLB read port.
- Accepts reads of up to DATA_BYTES bytes at any byte alignment.
- Splits a read that crosses a 2^LINE_W-byte line into two TLB requests, then merges the two returns into one little-endian result.
- Adds fault attribution (which piece faulted, and the faulting linear address) so the page-fault path can load CR2 directly.

---
 rtl/memory_read_split_pkg.sv | 19 +
 rtl/memory_read_merge.sv | 22 ++
 rtl/memory_read_split.sv | 156 +++++++++++++++
 tb/tb_memory_read_split.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/memory_read_split_pkg.sv
// Shared types for the read splitter: FSM encodings and the split descriptor.
package memory_read_split_pkg;

    localparam int SPLIT_LEN_W = 8;

    typedef enum logic [1:0] {
        STATE_IDLE   = 2'd0,
        STATE_FIRST  = 2'd1,
        STATE_SECOND = 2'd2
    } state_t;

    // Length fields are wide enough for any LINE_W up to 7.
    typedef struct packed {
        logic [SPLIT_LEN_W-1:0] len1;
        logic [SPLIT_LEN_W-1:0] len2;
        logic [31:0]            addr2;
    } split_info;

endpackage

// File: rtl/memory_read_merge.sv
// Byte-lane merge of two pieces: low lo_len bytes from lo_data, the rest from hi_data shifted up.
module memory_read_merge #(
    parameter int DATA_BYTES = 8,
    parameter int LEN_W      = 4,
    localparam int DW        = 8 * DATA_BYTES
) (
    input  logic [DW-1:0]    lo_data,
    input  logic [DW-1:0]    hi_data,
    input  logic [LEN_W-1:0] lo_len,
    output logic [DW-1:0]    merged
);

    logic [LEN_W+2:0] shift_bits;
    logic [DW-1:0]    lo_mask;

    always_comb begin
        shift_bits = {lo_len, 3'b000};
        lo_mask    = ~({DW{1'b1}} << shift_bits);
        merged     = (hi_data << shift_bits) | (lo_data & lo_mask);
    end

endmodule

// File: rtl/memory_read_split.sv
// Splits line-crossing reads into two TLB pieces, merges the returns and attributes faults.
module memory_read_split
    import memory_read_split_pkg::*;
#(
    parameter int LINE_W     = 4,
    parameter int DATA_BYTES = 8,
    parameter int LEN_W      = 4,
    localparam int DW        = 8 * DATA_BYTES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rd_reset,
    input  logic             read_do,
    output logic             read_done,
    output logic             read_page_fault,
    output logic             read_ac_fault,
    output logic             read_fault_second,
    output logic [31:0]      read_fault_address,
    input  logic [1:0]       read_cpl,
    input  logic [31:0]      read_address,
    input  logic [LEN_W-1:0] read_length,
    input  logic             read_lock,
    input  logic             read_rmw,
    output logic [DW-1:0]    read_data,
    output logic             tlbread_do,
    input  logic             tlbread_done,
    input  logic             tlbread_page_fault,
    input  logic             tlbread_ac_fault,
    input  logic             tlbread_retry,
    output logic [1:0]       tlbread_cpl,
    output logic [31:0]      tlbread_address,
    output logic [LEN_W-1:0] tlbread_length,
    output logic [LEN_W-1:0] tlbread_length_full,
    output logic             tlbread_lock,
    output logic             tlbread_rmw,
    input  logic [DW-1:0]    tlbread_data
);

    localparam int SW = LINE_W + 1;

    state_t            state, state_nxt;
    logic              reset_waiting;
    logic [LEN_W-1:0]  len2_reg;
    logic [31:0]       addr2_reg;
    logic [DW-9:0]     buffer;
    logic [SW-1:0]     left, len_ext, len1, len2;
    split_info         split;
    logic [LEN_W-1:0]  len1_piece;
    logic [DW-1:0]     merged;
    logic              busy, tlb_fault, abort, take_first, finish;

    assign tlbread_cpl         = read_cpl;
    assign tlbread_length_full = read_length;
    assign tlbread_lock        = read_lock;
    assign tlbread_rmw         = read_rmw;

    always_comb begin
        left        = SW'(1 << LINE_W) - SW'(read_address[LINE_W-1:0]);
        len_ext     = SW'(read_length);
        len1        = (left < len_ext) ? left : len_ext;
        len2        = len_ext - len1;
        split.len1  = SPLIT_LEN_W'(len1);
        split.len2  = SPLIT_LEN_W'(len2);
        split.addr2 = {read_address[31:LINE_W], {LINE_W{1'b0}}} + 32'(1 << LINE_W);
        len1_piece  = LEN_W'(split.len1);
    end

    memory_read_merge #(.DATA_BYTES(DATA_BYTES), .LEN_W(LEN_W)) u_merge (
        .lo_data (DW'(buffer)),
        .hi_data (tlbread_data),
        .lo_len  (len1_piece),
        .merged  (merged)
    );

    // A retry only aborts a piece once a flush is pending; otherwise the TLB reissues it.
    always_comb begin
        busy       = (state != STATE_IDLE);
        tlb_fault  = tlbread_page_fault | tlbread_ac_fault;
        abort      = tlb_fault | (tlbread_retry & reset_waiting);
        take_first = busy & ~abort & tlbread_done & (state == STATE_FIRST) & (len2_reg != '0);
        finish     = busy & ~abort & tlbread_done & ~take_first;
    end

    always_comb begin
        state_nxt       = state;
        tlbread_do      = 1'b0;
        tlbread_address = read_address;
        tlbread_length  = len1_piece;
        case (state)
            STATE_IDLE: begin
                if (read_do & ~read_done & ~rd_reset & ~read_page_fault & ~read_ac_fault) begin
                    tlbread_do = 1'b1;
                    state_nxt  = STATE_FIRST;
                end
            end
            STATE_FIRST, STATE_SECOND: begin
                tlbread_do = 1'b1;
                if (state == STATE_SECOND) begin
                    tlbread_address = addr2_reg;
                    tlbread_length  = len2_reg;
                end
                if (abort | finish) state_nxt = STATE_IDLE;
                else if (take_first) state_nxt = STATE_SECOND;
            end
            default: state_nxt = STATE_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state              <= STATE_IDLE;
            reset_waiting      <= 1'b0;
            len2_reg           <= '0;
            addr2_reg          <= '0;
            buffer             <= '0;
            read_done          <= 1'b0;
            read_data          <= '0;
            read_page_fault    <= 1'b0;
            read_ac_fault      <= 1'b0;
            read_fault_second  <= 1'b0;
            read_fault_address <= '0;
        end else begin
            state     <= state_nxt;
            read_done <= 1'b0;
            if (state == STATE_IDLE) begin
                reset_waiting <= 1'b0;
                len2_reg      <= LEN_W'(split.len2);
                addr2_reg     <= split.addr2;
            end else if (rd_reset) begin
                reset_waiting <= 1'b1;
            end
            if (take_first) buffer <= tlbread_data[DW-9:0];
            if (finish & ~rd_reset & ~reset_waiting) begin
                read_done <= 1'b1;
                read_data <= (state == STATE_SECOND) ? merged : tlbread_data;
            end
            if (rd_reset) begin
                read_page_fault    <= 1'b0;
                read_ac_fault      <= 1'b0;
                read_fault_second  <= 1'b0;
                read_fault_address <= '0;
            end else if (busy & tlb_fault & ~reset_waiting) begin
                read_page_fault    <= read_page_fault | tlbread_page_fault;
                read_ac_fault      <= read_ac_fault | tlbread_ac_fault;
                read_fault_second  <= (state == STATE_SECOND);
                read_fault_address <= tlbread_address;
            end
        end
    end

    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(DATA_BYTES);

    a_legal_length: assert property (@(posedge clk) disable iff (!rst_n)
        (read_do && state == STATE_IDLE) |-> (read_length != '0 && read_length <= MAX_LEN));

endmodule

// File: tb/tb_memory_read_split.sv
// Directed checks of the read splitter: plain, split, wrapped, faulting and flushed reads.
module tb_memory_read_split;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    int          n_checks = 0;
    int          n_fail = 0;

    // Default-parameter instance
    logic        rd_reset = 0, read_do = 0, read_lock = 0, read_rmw = 0;
    logic        read_done, read_page_fault, read_ac_fault, read_fault_second;
    logic [31:0] read_fault_address, read_address = 0, tlbread_address;
    logic [1:0]  read_cpl = 0, tlbread_cpl;
    logic [3:0]  read_length = 0, tlbread_length, tlbread_length_full;
    logic [63:0] read_data, tlbread_data = 0;
    logic        tlbread_do, tlbread_done = 0, tlbread_page_fault = 0, tlbread_ac_fault = 0;
    logic        tlbread_retry = 0, tlbread_lock, tlbread_rmw;

    // Wide instance: 32-byte lines, 16-byte accesses
    logic         b_rd_reset = 0, b_read_do = 0;
    logic         b_read_done, b_read_page_fault, b_read_ac_fault, b_read_fault_second;
    logic [31:0]  b_read_fault_address, b_read_address = 0, b_tlbread_address;
    logic [1:0]   b_tlbread_cpl;
    logic [4:0]   b_read_length = 0, b_tlbread_length, b_tlbread_length_full;
    logic [127:0] b_read_data, b_tlbread_data = 0;
    logic         b_tlbread_do, b_tlbread_done = 0, b_tlbread_lock, b_tlbread_rmw;

    always #5 clk = ~clk;

    memory_read_split dut (
        .clk(clk), .rst_n(rst_n), .rd_reset(rd_reset), .read_do(read_do),
        .read_done(read_done), .read_page_fault(read_page_fault), .read_ac_fault(read_ac_fault),
        .read_fault_second(read_fault_second), .read_fault_address(read_fault_address),
        .read_cpl(read_cpl), .read_address(read_address), .read_length(read_length),
        .read_lock(read_lock), .read_rmw(read_rmw), .read_data(read_data),
        .tlbread_do(tlbread_do), .tlbread_done(tlbread_done), .tlbread_page_fault(tlbread_page_fault),
        .tlbread_ac_fault(tlbread_ac_fault), .tlbread_retry(tlbread_retry), .tlbread_cpl(tlbread_cpl),
        .tlbread_address(tlbread_address), .tlbread_length(tlbread_length),
        .tlbread_length_full(tlbread_length_full), .tlbread_lock(tlbread_lock),
        .tlbread_rmw(tlbread_rmw), .tlbread_data(tlbread_data)
    );

    memory_read_split #(.LINE_W(5), .DATA_BYTES(16), .LEN_W(5)) dut_wide (
        .clk(clk), .rst_n(rst_n), .rd_reset(b_rd_reset), .read_do(b_read_do),
        .read_done(b_read_done), .read_page_fault(b_read_page_fault), .read_ac_fault(b_read_ac_fault),
        .read_fault_second(b_read_fault_second), .read_fault_address(b_read_fault_address),
        .read_cpl(2'd3), .read_address(b_read_address), .read_length(b_read_length),
        .read_lock(1'b0), .read_rmw(1'b0), .read_data(b_read_data),
        .tlbread_do(b_tlbread_do), .tlbread_done(b_tlbread_done), .tlbread_page_fault(1'b0),
        .tlbread_ac_fault(1'b0), .tlbread_retry(1'b0), .tlbread_cpl(b_tlbread_cpl),
        .tlbread_address(b_tlbread_address), .tlbread_length(b_tlbread_length),
        .tlbread_length_full(b_tlbread_length_full), .tlbread_lock(b_tlbread_lock),
        .tlbread_rmw(b_tlbread_rmw), .tlbread_data(b_tlbread_data)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2;
        n_checks++;
        if ({read_done, read_page_fault, read_ac_fault, read_fault_second, tlbread_do} !== 5'b0 ||
            read_data !== 64'h0 || read_fault_address !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: done=%b pf=%b data=%h fa=%h do=%b, want all zero",
                     read_done, read_page_fault, read_data, read_fault_address, tlbread_do);
        end
        n_checks++;
        if (b_read_data !== 128'h0 || b_read_done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_wide: data=%h done=%b, want 0", b_read_data, b_read_done);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_single();
        read_address = 32'h1000; read_length = 4'd4; read_cpl = 2'd2; read_lock = 1'b1; read_do = 1'b1;
        #1;
        n_checks++;
        if (tlbread_do !== 1'b1 || tlbread_address !== 32'h1000 || tlbread_length !== 4'd4) begin
            n_fail++;
            $display("FAIL single_req: do=%b addr=%h len=%0d, want 1 1000 4", tlbread_do, tlbread_address, tlbread_length);
        end
        n_checks++;
        if (tlbread_cpl !== 2'd2 || tlbread_lock !== 1'b1 || tlbread_length_full !== 4'd4) begin
            n_fail++;
            $display("FAIL passthru: cpl=%0d lock=%b full=%0d, want 2 1 4", tlbread_cpl, tlbread_lock, tlbread_length_full);
        end
        step();
        step();
        tlbread_done = 1'b1; tlbread_data = 64'h11223344;
        step();
        tlbread_done = 1'b0; read_do = 1'b0; read_lock = 1'b0;
        n_checks++;
        if (read_done !== 1'b1 || read_data !== 64'h11223344) begin
            n_fail++;
            $display("FAIL single_done: done=%b data=%h, want 1 11223344", read_done, read_data);
        end
        step();
        n_checks++;
        if (read_done !== 1'b0 || tlbread_do !== 1'b0) begin
            n_fail++;
            $display("FAIL single_pulse: done=%b do=%b, want 0 0", read_done, tlbread_do);
        end
    endtask

    task automatic test_split();
        read_address = 32'h100D; read_length = 4'd8; read_do = 1'b1;
        #1;
        n_checks++;
        if (tlbread_address !== 32'h100D || tlbread_length !== 4'd3) begin
            n_fail++;
            $display("FAIL split_p1: addr=%h len=%0d, want 100d 3", tlbread_address, tlbread_length);
        end
        step();
        tlbread_done = 1'b1; tlbread_data = 64'hAABBCC;
        step();
        tlbread_done = 1'b0;
        n_checks++;
        if (tlbread_do !== 1'b1 || tlbread_address !== 32'h1010 || tlbread_length !== 4'd5 || read_done !== 1'b0) begin
            n_fail++;
            $display("FAIL split_p2: do=%b addr=%h len=%0d done=%b, want 1 1010 5 0",
                     tlbread_do, tlbread_address, tlbread_length, read_done);
        end
        tlbread_done = 1'b1; tlbread_data = 64'h0102030405;
        step();
        tlbread_done = 1'b0; read_do = 1'b0;
        n_checks++;
        if (read_done !== 1'b1 || read_data !== 64'h0102030405AABBCC) begin
            n_fail++;
            $display("FAIL split_merge: done=%b data=%h, want 1 0102030405aabbcc", read_done, read_data);
        end
        step();
    endtask

    task automatic test_fault_second();
        read_address = 32'h100E; read_length = 4'd4; read_do = 1'b1;
        step();
        tlbread_done = 1'b1; tlbread_data = 64'h2211;
        step();
        tlbread_done = 1'b0; tlbread_page_fault = 1'b1;
        #1;
        n_checks++;
        if (tlbread_address !== 32'h1010 || tlbread_length !== 4'd2) begin
            n_fail++;
            $display("FAIL fault_p2_req: addr=%h len=%0d, want 1010 2", tlbread_address, tlbread_length);
        end
        step();
        tlbread_page_fault = 1'b0; read_do = 1'b0;
        n_checks++;
        if (read_page_fault !== 1'b1 || read_fault_second !== 1'b1 || read_fault_address !== 32'h1010 ||
            read_ac_fault !== 1'b0 || read_done !== 1'b0) begin
            n_fail++;
            $display("FAIL fault_latch: pf=%b sec=%b fa=%h ac=%b done=%b, want 1 1 1010 0 0",
                     read_page_fault, read_fault_second, read_fault_address, read_ac_fault, read_done);
        end
        n_checks++;
        if (read_data !== 64'h0102030405AABBCC) begin
            n_fail++;
            $display("FAIL fault_data_hold: data=%h, want 0102030405aabbcc", read_data);
        end
        rd_reset = 1'b1;
        step();
        rd_reset = 1'b0;
        n_checks++;
        if (read_page_fault !== 1'b0 || read_fault_second !== 1'b0 || read_fault_address !== 32'h0) begin
            n_fail++;
            $display("FAIL fault_clear: pf=%b sec=%b fa=%h, want 0 0 0", read_page_fault, read_fault_second, read_fault_address);
        end
    endtask

    task automatic test_flush();
        read_address = 32'h2000; read_length = 4'd4; read_do = 1'b1;
        step();
        rd_reset = 1'b1; read_do = 1'b0;
        step();
        rd_reset = 1'b0;
        n_checks++;
        if (tlbread_do !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_hold: do=%b, want 1", tlbread_do);
        end
        tlbread_retry = 1'b1;
        step();
        tlbread_retry = 1'b0; tlbread_done = 1'b1; tlbread_data = 64'hDEAD;
        step();
        tlbread_done = 1'b0;
        step();
        n_checks++;
        if (read_done !== 1'b0 || read_page_fault !== 1'b0 || tlbread_do !== 1'b0 ||
            read_data !== 64'h0102030405AABBCC) begin
            n_fail++;
            $display("FAIL flush_quiet: done=%b pf=%b do=%b data=%h, want 0 0 0 0102030405aabbcc",
                     read_done, read_page_fault, tlbread_do, read_data);
        end
    endtask

    task automatic test_back_to_back();
        read_address = 32'h3004; read_length = 4'd2; read_do = 1'b1;
        step();
        tlbread_retry = 1'b1;
        step();
        tlbread_retry = 1'b0;
        n_checks++;
        if (tlbread_do !== 1'b1 || tlbread_address !== 32'h3004 || read_done !== 1'b0) begin
            n_fail++;
            $display("FAIL bare_retry: do=%b addr=%h done=%b, want 1 3004 0", tlbread_do, tlbread_address, read_done);
        end
        tlbread_done = 1'b1; tlbread_data = 64'hBEEF;
        step();
        tlbread_done = 1'b0; read_do = 1'b0;
        n_checks++;
        if (read_done !== 1'b1 || read_data !== 64'hBEEF) begin
            n_fail++;
            $display("FAIL after_flush: done=%b data=%h, want 1 beef", read_done, read_data);
        end
        step();
    endtask

    task automatic test_wrap();
        read_address = 32'hFFFFFFFC; read_length = 4'd8; read_do = 1'b1;
        #1;
        n_checks++;
        if (tlbread_length !== 4'd4) begin
            n_fail++;
            $display("FAIL wrap_p1: len=%0d, want 4", tlbread_length);
        end
        step();
        tlbread_done = 1'b1; tlbread_data = 64'hFFFFFFFF44332211;
        step();
        tlbread_done = 1'b0;
        n_checks++;
        if (tlbread_address !== 32'h0 || tlbread_length !== 4'd4) begin
            n_fail++;
            $display("FAIL wrap_p2: addr=%h len=%0d, want 0 4", tlbread_address, tlbread_length);
        end
        tlbread_done = 1'b1; tlbread_data = 64'h88776655;
        step();
        tlbread_done = 1'b0; read_do = 1'b0;
        n_checks++;
        if (read_done !== 1'b1 || read_data !== 64'h8877665544332211) begin
            n_fail++;
            $display("FAIL wrap_merge: done=%b data=%h, want 1 8877665544332211", read_done, read_data);
        end
        step();
    endtask

    task automatic test_wide();
        b_read_address = 32'h1F; b_read_length = 5'd16; b_read_do = 1'b1;
        #1;
        n_checks++;
        if (b_tlbread_do !== 1'b1 || b_tlbread_address !== 32'h1F || b_tlbread_length !== 5'd1) begin
            n_fail++;
            $display("FAIL wide_p1: do=%b addr=%h len=%0d, want 1 1f 1", b_tlbread_do, b_tlbread_address, b_tlbread_length);
        end
        step();
        b_tlbread_done = 1'b1; b_tlbread_data = {120'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFF, 8'h5A};
        step();
        b_tlbread_done = 1'b0;
        n_checks++;
        if (b_tlbread_address !== 32'h20 || b_tlbread_length !== 5'd15) begin
            n_fail++;
            $display("FAIL wide_p2: addr=%h len=%0d, want 20 15", b_tlbread_address, b_tlbread_length);
        end
        b_tlbread_done = 1'b1; b_tlbread_data = 128'h000F0E0D0C0B0A090807060504030201;
        step();
        b_tlbread_done = 1'b0; b_read_do = 1'b0;
        n_checks++;
        if (b_read_done !== 1'b1 || b_read_data !== 128'h0F0E0D0C0B0A0908070605040302015A) begin
            n_fail++;
            $display("FAIL wide_merge: done=%b data=%h, want 1 0f0e0d0c0b0a0908070605040302015a", b_read_done, b_read_data);
        end
        step();
    endtask

    initial begin
        test_reset();
        test_single();
        test_split();
        test_fault_second();
        test_flush();
        test_back_to_back();
        test_wrap();
        test_wide();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
